commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Synthesizable successor to the passive tracer interface. It captures per-cycle commit-port retirements, filtered by trace enable and privilege mask, into a circular FIFO.
- The FIFO drains one timestamped record per cycle over a valid/ready port toward an off-core trace sink.
- Generalised over commit-port count, depth and data width. Adds overflow accounting, which the passive interface lacks: atomic drop, a saturating drop counter and a gap flag.

Parameters:
- NR_COMMIT_PORTS, 2, number of commit ports sampled per cycle (1..4).
- DEPTH, 16, FIFO entries; power of two, must be >= NR_COMMIT_PORTS.
- XLEN, 64, width of PC, write data and exception cause.
- TS_W, 32, timestamp counter width.
- DROP_W, 16, drop counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- trace_en_i  in  1  capture enable
- priv_mask_i  in  4  bit p set = record commits at priv level p (U=0, S=1, M=3)
- flush_i  in  1  empty FIFO; counters kept
- clr_drop_i  in  1  clear drop counter
- commit_ack_i  in  NR_COMMIT_PORTS  per-port commit strobe
- commit_pc_i  in  NR_COMMIT_PORTS*XLEN  PC, port k at [k*XLEN +: XLEN]
- commit_instr_i  in  NR_COMMIT_PORTS*32  instruction word
- commit_wdata_i  in  NR_COMMIT_PORTS*XLEN  writeback data
- commit_waddr_i  in  NR_COMMIT_PORTS*5  destination register
- commit_we_gpr_i  in  NR_COMMIT_PORTS  GPR write
- commit_we_fpr_i  in  NR_COMMIT_PORTS  FPR write
- commit_ex_valid_i  in  NR_COMMIT_PORTS  exception on this commit
- commit_ex_cause_i  in  NR_COMMIT_PORTS*XLEN  exception cause
- priv_lvl_i  in  2  current privilege level
- trace_valid_o  out  1  record available
- trace_ready_i  in  1  sink accepts record
- trace_pc_o  out  XLEN  record PC
- trace_instr_o  out  32  record instruction
- trace_wdata_o  out  XLEN  record writeback data
- trace_waddr_o  out  5  record destination register
- trace_we_gpr_o  out  1  record GPR write flag
- trace_we_fpr_o  out  1  record FPR write flag
- trace_priv_o  out  2  record privilege level
- trace_ex_valid_o  out  1  record exception flag
- trace_ex_cause_o  out  XLEN  record exception cause
- trace_ts_o  out  TS_W  capture-cycle timestamp
- trace_gap_o  out  1  records were lost immediately before this one
- drop_cnt_o  out  DROP_W  records dropped, saturating
- full_o  out  1  count == DEPTH

Behaviour:
- Reset (rst_i=1 at clk_i edge):
  - rd_ptr, wr_ptr, count, timestamp, drop_cnt cleared to 0; gap_pending cleared to 0.
  - All outputs read 0; trace_valid_o=0.
  - Reset mid-transfer discards all contents.
- Timestamp:
  - Free-running, +1 every cycle, wraps at 2^TS_W.
  - A record stores the timestamp value of its capture cycle.
- Qualification: port k is eligible when commit_ack_i[k] & trace_en_i & (priv_mask_i[priv_lvl_i] | commit_ex_valid_i[k]). Exceptions bypass the privilege mask.
- Push:
  - n = popcount(eligible). Eligible ports are written in ascending port order at wr_ptr, wr_ptr+1, ..., modulo DEPTH.
  - Space check: (DEPTH - count) >= n, using count at the start of the cycle. A same-cycle pop is not credited.
  - If the check fails, all n records of that cycle are dropped (atomic, never partial). drop_cnt += n, saturating at 2^DROP_W-1, and gap_pending is set.
- Gap flag:
  - The first record pushed after gap_pending is set carries gap=1; gap_pending then clears.
  - If several ports push in that cycle, only the lowest-port record carries gap=1.
- Pop:
  - trace_valid_o = (count != 0).
  - Record at rd_ptr is presented combinationally from the FIFO storage.
  - Transfer when valid & ready: rd_ptr+1 modulo DEPTH.
  - Output is stable while valid & !ready.
- Count update: count_next = count + pushed - popped. Simultaneous push and pop are legal.
- flush_i:
  - rd_ptr=wr_ptr=count=0 next cycle; pushes and pops in the flush cycle are ignored.
  - drop_cnt and timestamp are kept; gap_pending is set if count != 0.
- clr_drop_i: drop_cnt=0 next cycle; takes priority over a concurrent increment.
- full_o reflects the registered count.
- Latency: capture to trace_valid_o is 1 cycle when the FIFO was empty.

Test Plan:
- Reset, then trace_en=1, priv_mask=4'b1000, priv=M, port0 ack pc=0x8000_0000, ready=1 -> next cycle valid=1, pc=0x8000_0000, ts=capture ts, gap=0; one-cycle valid pulse.
- Both ports ack in one cycle, pc 0x100 (p0) and 0x104 (p1), ready=0 -> count=2; after ready=1, records pop in order 0x100 then 0x104.
- priv=U, mask=4'b1000: a non-exception commit is not recorded; an exception commit with cause=2 is recorded, ex_valid=1, cause=2.
- DEPTH=16, ready=0: fill to 15, then a 2-port commit -> both dropped, count stays 15, drop_cnt=2. Then a 1-port commit at 15 -> accepted, gap=1 on that record, full_o=1.
- Full FIFO with ready=1 and a 1-port commit in the same cycle -> push dropped (pop not credited), drop_cnt +1, count=15.
- flush_i while count=5 -> count=0, valid=0 next cycle, drop_cnt unchanged. Next record has gap=1.
- clr_drop_i in the same cycle as a drop -> drop_cnt=0.
- Saturate drop_cnt at 0xFFFF under continuous overflow -> it holds at 0xFFFF.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: filters per-cycle commit-port retirements into a circular
// FIFO of timestamped records, drained one per cycle over a valid/ready port.
module commit_trace_buffer #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 16,
    parameter int XLEN            = 64,
    parameter int TS_W            = 32,
    parameter int DROP_W          = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            trace_en_i,
    input  logic [3:0]                      priv_mask_i,
    input  logic                            flush_i,
    input  logic                            clr_drop_i,
    input  logic [NR_COMMIT_PORTS-1:0]      commit_ack_i,
    input  logic [NR_COMMIT_PORTS*XLEN-1:0] commit_pc_i,
    input  logic [NR_COMMIT_PORTS*32-1:0]   commit_instr_i,
    input  logic [NR_COMMIT_PORTS*XLEN-1:0] commit_wdata_i,
    input  logic [NR_COMMIT_PORTS*5-1:0]    commit_waddr_i,
    input  logic [NR_COMMIT_PORTS-1:0]      commit_we_gpr_i,
    input  logic [NR_COMMIT_PORTS-1:0]      commit_we_fpr_i,
    input  logic [NR_COMMIT_PORTS-1:0]      commit_ex_valid_i,
    input  logic [NR_COMMIT_PORTS*XLEN-1:0] commit_ex_cause_i,
    input  logic [1:0]                      priv_lvl_i,
    output logic                            trace_valid_o,
    input  logic                            trace_ready_i,
    output logic [XLEN-1:0]                 trace_pc_o,
    output logic [31:0]                     trace_instr_o,
    output logic [XLEN-1:0]                 trace_wdata_o,
    output logic [4:0]                      trace_waddr_o,
    output logic                            trace_we_gpr_o,
    output logic                            trace_we_fpr_o,
    output logic [1:0]                      trace_priv_o,
    output logic                            trace_ex_valid_o,
    output logic [XLEN-1:0]                 trace_ex_cause_o,
    output logic [TS_W-1:0]                 trace_ts_o,
    output logic                            trace_gap_o,
    output logic [DROP_W-1:0]               drop_cnt_o,
    output logic                            full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] wdata;
        logic [4:0]      waddr;
        logic            we_gpr;
        logic            we_fpr;
        logic [1:0]      priv;
        logic            ex_valid;
        logic [XLEN-1:0] ex_cause;
        logic [TS_W-1:0] ts;
        logic            gap;
    } rec_t;

    rec_t             mem_r [DEPTH];
    rec_t             new_rec_s [NR_COMMIT_PORTS];
    logic [PTR_W-1:0] off_s [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] elig_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic [CNT_W-1:0] n_s;
    logic [TS_W-1:0]  ts_r;
    logic [DROP_W-1:0] drop_cnt_r;
    logic [DROP_W:0]  drop_sum_s;
    logic             gap_pending_r;
    logic             space_ok_s;
    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic             valid_s;
    rec_t             out_s;

    // Qualify each port and pack eligible commits densely in ascending port order
    always_comb begin
        n_s = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            elig_s[k] = commit_ack_i[k] & trace_en_i
                        & (priv_mask_i[priv_lvl_i] | commit_ex_valid_i[k]);
            off_s[k]  = n_s[PTR_W-1:0];
            n_s       = n_s + CNT_W'(elig_s[k]);
            new_rec_s[k].pc       = commit_pc_i[k*XLEN +: XLEN];
            new_rec_s[k].instr    = commit_instr_i[k*32 +: 32];
            new_rec_s[k].wdata    = commit_wdata_i[k*XLEN +: XLEN];
            new_rec_s[k].waddr    = commit_waddr_i[k*5 +: 5];
            new_rec_s[k].we_gpr   = commit_we_gpr_i[k];
            new_rec_s[k].we_fpr   = commit_we_fpr_i[k];
            new_rec_s[k].priv     = priv_lvl_i;
            new_rec_s[k].ex_valid = commit_ex_valid_i[k];
            new_rec_s[k].ex_cause = commit_ex_cause_i[k*XLEN +: XLEN];
            new_rec_s[k].ts       = ts_r;
            // Only the first record written after a loss carries the gap marker
            new_rec_s[k].gap      = gap_pending_r & (off_s[k] == '0);
        end
    end

    // Space check uses start-of-cycle count; a concurrent pop is not credited
    always_comb begin
        valid_s      = (count_r != '0);
        space_ok_s   = ((DEPTH_C - count_r) >= n_s);
        push_s       = ~flush_i & space_ok_s & (n_s != '0);
        drop_s       = ~flush_i & ~space_ok_s;
        pop_s        = ~flush_i & valid_s & trace_ready_i;
        count_next_s = count_r + (push_s ? n_s : {CNT_W{1'b0}}) - CNT_W'(pop_s);
        drop_sum_s   = {1'b0, drop_cnt_r} + (DROP_W+1)'(n_s);
        if (valid_s) begin
            out_s = mem_r[rd_ptr_r];
        end else begin
            out_s = '0;
        end
    end

    // Pointer, occupancy, timestamp and loss-accounting state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            ts_r          <= '0;
            drop_cnt_r    <= '0;
            gap_pending_r <= 1'b0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
            if (flush_i) begin
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
                count_r  <= '0;
                if (count_r != '0) begin
                    gap_pending_r <= 1'b1;
                end
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + n_s[PTR_W-1:0];
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                count_r <= count_next_s;
                if (drop_s) begin
                    gap_pending_r <= 1'b1;
                end else if (push_s) begin
                    gap_pending_r <= 1'b0;
                end
            end
            if (clr_drop_i) begin
                drop_cnt_r <= '0;
            end else if (drop_s) begin
                drop_cnt_r <= drop_sum_s[DROP_W] ? DROP_MAX : drop_sum_s[DROP_W-1:0];
            end
        end
    end

    // Record storage; contents need no reset because outputs are masked when empty
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
                if (elig_s[k]) begin
                    mem_r[wr_ptr_r + off_s[k]] <= new_rec_s[k];
                end
            end
        end
    end

    assign trace_valid_o    = valid_s;
    assign trace_pc_o       = out_s.pc;
    assign trace_instr_o    = out_s.instr;
    assign trace_wdata_o    = out_s.wdata;
    assign trace_waddr_o    = out_s.waddr;
    assign trace_we_gpr_o   = out_s.we_gpr;
    assign trace_we_fpr_o   = out_s.we_fpr;
    assign trace_priv_o     = out_s.priv;
    assign trace_ex_valid_o = out_s.ex_valid;
    assign trace_ex_cause_o = out_s.ex_cause;
    assign trace_ts_o       = out_s.ts;
    assign trace_gap_o      = out_s.gap;
    assign drop_cnt_o       = drop_cnt_r;
    assign full_o           = (count_r == DEPTH_C);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus randomized
// traffic compared against a queue-based model of the trace FIFO.
module tb_commit_trace_buffer;

    localparam int NP = 2;
    localparam int DEPTH = 16;

    logic          clk_i = 1'b0;
    logic          rst_i, trace_en_i, flush_i, clr_drop_i, trace_ready_i;
    logic [3:0]    priv_mask_i;
    logic [1:0]    priv_lvl_i;
    logic [NP-1:0] commit_ack_i, commit_we_gpr_i, commit_we_fpr_i, commit_ex_valid_i;
    logic [NP*64-1:0] commit_pc_i, commit_wdata_i, commit_ex_cause_i;
    logic [NP*32-1:0] commit_instr_i;
    logic [NP*5-1:0]  commit_waddr_i;
    logic          trace_valid_o, trace_we_gpr_o, trace_we_fpr_o, trace_ex_valid_o;
    logic          trace_gap_o, full_o;
    logic [63:0]   trace_pc_o, trace_wdata_o, trace_ex_cause_o;
    logic [31:0]   trace_instr_o, trace_ts_o;
    logic [4:0]    trace_waddr_o;
    logic [1:0]    trace_priv_o;
    logic [15:0]   drop_cnt_o;

    commit_trace_buffer #(.NR_COMMIT_PORTS(NP), .DEPTH(DEPTH), .XLEN(64), .TS_W(32), .DROP_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .trace_en_i(trace_en_i), .priv_mask_i(priv_mask_i),
        .flush_i(flush_i), .clr_drop_i(clr_drop_i), .commit_ack_i(commit_ack_i),
        .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i), .commit_wdata_i(commit_wdata_i),
        .commit_waddr_i(commit_waddr_i), .commit_we_gpr_i(commit_we_gpr_i),
        .commit_we_fpr_i(commit_we_fpr_i), .commit_ex_valid_i(commit_ex_valid_i),
        .commit_ex_cause_i(commit_ex_cause_i), .priv_lvl_i(priv_lvl_i),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o),
        .trace_instr_o(trace_instr_o), .trace_wdata_o(trace_wdata_o), .trace_waddr_o(trace_waddr_o),
        .trace_we_gpr_o(trace_we_gpr_o), .trace_we_fpr_o(trace_we_fpr_o), .trace_priv_o(trace_priv_o),
        .trace_ex_valid_o(trace_ex_valid_o), .trace_ex_cause_o(trace_ex_cause_o),
        .trace_ts_o(trace_ts_o), .trace_gap_o(trace_gap_o), .drop_cnt_o(drop_cnt_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic valid; logic full; logic [15:0] drop;
        logic [63:0] pc; logic [31:0] instr; logic [63:0] wdata; logic [4:0] waddr;
        logic gpr; logic fpr; logic [1:0] priv; logic exv; logic [63:0] cause;
        logic [31:0] ts; logic gap;
    } view_t;

    view_t       q[$];
    int          m_drop = 0;
    logic [31:0] m_ts = 32'd0;
    logic        m_gap = 1'b0;
    int          errors = 0;
    int          checks = 0;

    // Reference model: one call per clock edge, from the inputs present at that edge.
    task automatic model_update();
        view_t nr[$];
        view_t r;
        bit popped;
        if (rst_i) begin
            q.delete(); m_ts = 32'd0; m_drop = 0; m_gap = 1'b0;
            return;
        end
        for (int k = 0; k < NP; k++) begin
            if (commit_ack_i[k] && trace_en_i && (priv_mask_i[priv_lvl_i] || commit_ex_valid_i[k])) begin
                r = '0;
                r.pc = commit_pc_i[k*64 +: 64]; r.instr = commit_instr_i[k*32 +: 32];
                r.wdata = commit_wdata_i[k*64 +: 64]; r.waddr = commit_waddr_i[k*5 +: 5];
                r.gpr = commit_we_gpr_i[k]; r.fpr = commit_we_fpr_i[k]; r.priv = priv_lvl_i;
                r.exv = commit_ex_valid_i[k]; r.cause = commit_ex_cause_i[k*64 +: 64]; r.ts = m_ts;
                nr.push_back(r);
            end
        end
        if (flush_i) begin
            if (q.size() != 0) m_gap = 1'b1;
            q.delete();
        end else begin
            popped = (q.size() != 0) && trace_ready_i;
            if (nr.size() <= DEPTH - q.size()) begin
                foreach (nr[i]) begin
                    r = nr[i];
                    r.gap = (i == 0) && m_gap;
                    q.push_back(r);
                end
                if (nr.size() > 0) m_gap = 1'b0;
            end else begin
                m_drop = (m_drop + nr.size() > 65535) ? 65535 : m_drop + nr.size();
                m_gap = 1'b1;
            end
            if (popped) void'(q.pop_front());
        end
        if (clr_drop_i) m_drop = 0;
        m_ts = m_ts + 32'd1;
    endtask

    function automatic view_t exp_view();
        view_t v = '0;
        if (q.size() != 0) begin
            v = q[0];
            v.valid = 1'b1;
        end
        v.full = (q.size() == DEPTH);
        v.drop = 16'(m_drop);
        return v;
    endfunction

    function automatic view_t dut_view();
        view_t v;
        v.valid = trace_valid_o; v.full = full_o; v.drop = drop_cnt_o; v.pc = trace_pc_o;
        v.instr = trace_instr_o; v.wdata = trace_wdata_o; v.waddr = trace_waddr_o;
        v.gpr = trace_we_gpr_o; v.fpr = trace_we_fpr_o; v.priv = trace_priv_o;
        v.exv = trace_ex_valid_o; v.cause = trace_ex_cause_o; v.ts = trace_ts_o; v.gap = trace_gap_o;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic idle();
        commit_ack_i = '0; commit_ex_valid_i = '0; flush_i = 1'b0; clr_drop_i = 1'b0;
    endtask

    task automatic cfg(input logic en, input logic [3:0] mask, input logic [1:0] priv, input logic rdy);
        trace_en_i = en; priv_mask_i = mask; priv_lvl_i = priv; trace_ready_i = rdy;
    endtask

    task automatic put(input int k, input logic [63:0] pc, input logic ex, input logic [63:0] cause);
        commit_ack_i[k] = 1'b1;
        commit_pc_i[k*64 +: 64] = pc;
        commit_instr_i[k*32 +: 32] = $urandom;
        commit_wdata_i[k*64 +: 64] = {$urandom, $urandom};
        commit_waddr_i[k*5 +: 5] = 5'($urandom);
        commit_we_gpr_i[k] = 1'($urandom);
        commit_we_fpr_i[k] = 1'($urandom);
        commit_ex_valid_i[k] = ex;
        commit_ex_cause_i[k*64 +: 64] = cause;
    endtask

    task automatic do_reset();
        idle(); rst_i = 1'b1; step(); rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle(); rst_i = 1'b1; step(); step();
        checks++; if (dut_view() !== view_t'('0)) begin errors++; $display("FAIL reset_outputs: got %h want 0", dut_view()); end
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] cap_ts;
        cfg(1'b1, 4'b1000, 2'd3, 1'b1);
        put(0, 64'h8000_0000, 1'b0, 64'd0);
        cap_ts = m_ts;
        step(); idle();
        checks++; if (dut_view() !== exp_view()) begin errors++; $display("FAIL single_model: got %h want %h", dut_view(), exp_view()); end
        checks++;
        if (!(trace_valid_o === 1'b1 && trace_pc_o === 64'h8000_0000 && trace_ts_o === cap_ts && trace_gap_o === 1'b0)) begin
            errors++; $display("FAIL single_record: valid=%b pc=%h ts=%h gap=%b want 1 80000000 %h 0", trace_valid_o, trace_pc_o, trace_ts_o, trace_gap_o, cap_ts);
        end
        step();
        checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL single_pulse: valid=%b want 0", trace_valid_o); end
    endtask

    task automatic test_two_ports();
        cfg(1'b1, 4'b1000, 2'd3, 1'b0);
        put(0, 64'h100, 1'b0, 64'd0); put(1, 64'h104, 1'b0, 64'd0);
        step(); idle(); step();
        checks++; if (dut_view() !== exp_view() || trace_pc_o !== 64'h100) begin errors++; $display("FAIL two_first: got %h want %h", dut_view(), exp_view()); end
        trace_ready_i = 1'b1; step();
        checks++; if (dut_view() !== exp_view() || trace_pc_o !== 64'h104) begin errors++; $display("FAIL two_second: got %h want %h", dut_view(), exp_view()); end
        step();
        checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL two_empty: valid=%b want 0", trace_valid_o); end
    endtask

    task automatic test_priv();
        cfg(1'b1, 4'b1000, 2'd0, 1'b1);
        put(0, 64'h200, 1'b0, 64'd0); step(); idle();
        checks++; if (trace_valid_o !== 1'b0 || dut_view() !== exp_view()) begin errors++; $display("FAIL priv_filtered: got %h want %h", dut_view(), exp_view()); end
        put(0, 64'h204, 1'b1, 64'd2); step(); idle();
        checks++;
        if (dut_view() !== exp_view() || trace_ex_valid_o !== 1'b1 || trace_ex_cause_o !== 64'd2 || trace_pc_o !== 64'h204) begin
            errors++; $display("FAIL priv_exception: got %h want %h", dut_view(), exp_view());
        end
        step();
    endtask

    task automatic test_overflow();
        do_reset();
        cfg(1'b1, 4'b1000, 2'd3, 1'b0);
        for (int i = 0; i < 15; i++) begin
            idle(); put(0, 64'h1000 + 64'(i * 4), 1'b0, 64'd0); step();
        end
        idle(); put(0, 64'hAAA0, 1'b0, 64'd0); put(1, 64'hAAA4, 1'b0, 64'd0); step();
        checks++; if (drop_cnt_o !== 16'd2 || full_o !== 1'b0 || dut_view() !== exp_view()) begin errors++; $display("FAIL ovf_atomic_drop: got %h want %h", dut_view(), exp_view()); end
        idle(); put(0, 64'h5A5A, 1'b0, 64'd0); step(); idle();
        checks++; if (full_o !== 1'b1 || dut_view() !== exp_view()) begin errors++; $display("FAIL ovf_fill_full: got %h want %h", dut_view(), exp_view()); end
        trace_ready_i = 1'b1; put(0, 64'h6000, 1'b0, 64'd0); step(); idle();
        checks++; if (drop_cnt_o !== 16'd3 || full_o !== 1'b0 || dut_view() !== exp_view()) begin errors++; $display("FAIL ovf_pop_not_credited: got %h want %h", dut_view(), exp_view()); end
        for (int j = 0; j < 15; j++) begin
            checks++; if (dut_view() !== exp_view()) begin errors++; $display("FAIL ovf_drain: got %h want %h", dut_view(), exp_view()); end
            if (j == 14) begin
                checks++; if (trace_pc_o !== 64'h5A5A || trace_gap_o !== 1'b1) begin errors++; $display("FAIL ovf_gap_record: pc=%h gap=%b want 5a5a 1", trace_pc_o, trace_gap_o); end
            end
            step();
        end
        checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained: valid=%b want 0", trace_valid_o); end
    endtask

    task automatic test_flush();
        logic [15:0] drop_before;
        cfg(1'b1, 4'b1000, 2'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(); put(0, 64'h3000 + 64'(i), 1'b0, 64'd0); step();
        end
        drop_before = drop_cnt_o;
        idle(); flush_i = 1'b1; put(0, 64'h3100, 1'b0, 64'd0); step(); idle();
        checks++; if (trace_valid_o !== 1'b0 || drop_cnt_o !== drop_before || dut_view() !== exp_view()) begin errors++; $display("FAIL flush_empty: got %h want %h", dut_view(), exp_view()); end
        put(0, 64'h7000, 1'b0, 64'd0); step(); idle();
        checks++; if (trace_gap_o !== 1'b1 || trace_pc_o !== 64'h7000 || dut_view() !== exp_view()) begin errors++; $display("FAIL flush_gap: got %h want %h", dut_view(), exp_view()); end
        trace_ready_i = 1'b1; step();
    endtask

    task automatic test_saturate_clr();
        do_reset();
        cfg(1'b1, 4'b1000, 2'd3, 1'b0);
        put(0, 64'h10, 1'b0, 64'd0); put(1, 64'h14, 1'b0, 64'd0);
        for (int i = 0; i < 8 + 32770; i++) step();
        checks++; if (drop_cnt_o !== 16'hFFFF || dut_view() !== exp_view()) begin errors++; $display("FAIL sat_reach: got %h want %h", dut_view(), exp_view()); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: drop=%h want ffff", drop_cnt_o); end
        clr_drop_i = 1'b1; step(); clr_drop_i = 1'b0;
        checks++; if (drop_cnt_o !== 16'd0 || dut_view() !== exp_view()) begin errors++; $display("FAIL clr_priority: got %h want %h", dut_view(), exp_view()); end
        step();
        checks++; if (drop_cnt_o !== 16'd2 || dut_view() !== exp_view()) begin errors++; $display("FAIL clr_then_count: got %h want %h", dut_view(), exp_view()); end
        idle();
    endtask

    task automatic test_reset_mid();
        cfg(1'b1, 4'b1111, 2'd1, 1'b0);
        put(0, 64'h900, 1'b0, 64'd0); step(); step(); idle();
        trace_ready_i = 1'b1; rst_i = 1'b1; step(); rst_i = 1'b0;
        checks++; if (dut_view() !== view_t'('0) || dut_view() !== exp_view()) begin errors++; $display("FAIL reset_mid: got %h want 0", dut_view()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            idle();
            trace_en_i = ($urandom_range(7) != 0);
            priv_mask_i = 4'($urandom);
            priv_lvl_i = 2'($urandom);
            trace_ready_i = (i < 1500) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            for (int k = 0; k < NP; k++) begin
                if ($urandom_range(1) == 1) put(k, {$urandom, $urandom}, ($urandom_range(7) == 0), {$urandom, $urandom});
            end
            flush_i = ($urandom_range(63) == 0);
            clr_drop_i = ($urandom_range(63) == 0);
            step();
            checks++; if (dut_view() !== exp_view()) begin errors++; $display("FAIL random_cycle %0d: got %h want %h", i, dut_view(), exp_view()); end
        end
        idle();
    endtask

    initial begin
        rst_i = 1'b1; trace_en_i = 1'b0; priv_mask_i = 4'd0; priv_lvl_i = 2'd0;
        flush_i = 1'b0; clr_drop_i = 1'b0; trace_ready_i = 1'b0;
        commit_ack_i = '0; commit_we_gpr_i = '0; commit_we_fpr_i = '0; commit_ex_valid_i = '0;
        commit_pc_i = '0; commit_wdata_i = '0; commit_ex_cause_i = '0;
        commit_instr_i = '0; commit_waddr_i = '0;
        test_reset();
        test_single();
        test_two_ports();
        test_priv();
        test_overflow();
        test_flush();
        test_saturate_clr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
